// File: rtl/pipe_register_pkg.sv
// Shared limits for the valid/ready pipeline register.
package pipe_register_pkg;

  localparam int PIPE_REG_MAX_DEPTH = 8;
  localparam int PIPE_REG_MAX_WIDTH = 256;

endpackage : pipe_register_pkg

// File: rtl/pipe_register_stage.sv
// One valid/ready register stage. It loads from upstream whenever it is
// empty or its downstream is ready; otherwise it holds. Data only moves
// when a valid entry arrives, so empty stages do not toggle.
module pipe_register_stage
  import pipe_register_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  input  logic             dn_ready_i,
  output logic             ready_o,
  output logic             valid_d_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Ready/next-state: flush drops the valid bit but leaves data untouched.
  always_comb begin
    ready_o = !valid_q || dn_ready_i;
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (ready_o) begin
      valid_d = up_valid_i;
      if (up_valid_i) data_d = up_data_i;
    end
  end

  // Stage state with immediate reset to the configured data value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_d_o = valid_d;
  assign valid_o   = valid_q;
  assign data_o    = data_q;

endmodule : pipe_register_stage

// File: rtl/pipe_register.sv
// DEPTH-stage valid/ready pipeline register with bubble collapse, flush
// and a registered occupancy count.
module pipe_register
  import pipe_register_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  if (DEPTH < 1 || DEPTH > PIPE_REG_MAX_DEPTH) begin : g_bad_depth
    $error("pipe_register: DEPTH out of range 1..%0d", PIPE_REG_MAX_DEPTH);
  end
  if (WIDTH < 1 || WIDTH > PIPE_REG_MAX_WIDTH) begin : g_bad_width
    $error("pipe_register: WIDTH out of range 1..%0d", PIPE_REG_MAX_WIDTH);
  end

  // vld/dat index k is the input of stage k; index k+1 is its output.
  logic [DEPTH:0]              vld;
  logic [DEPTH:0][WIDTH-1:0]   dat;
  logic [DEPTH-1:0]            dn_rdy;
  logic [DEPTH-1:0]            st_rdy;
  logic [DEPTH-1:0]            vld_d;
  logic [OCC_W-1:0]            occ_q, occ_d;

  assign vld[0] = in_valid;
  assign dat[0] = in_data;

  // Downstream ready for each stage, walking back from the consumer. An
  // accumulator keeps the chain inside one block.
  always_comb begin
    logic acc;
    acc    = out_ready;
    dn_rdy = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      dn_rdy[k] = acc;
      acc       = acc | ~vld[k+1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    pipe_register_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (flush),
      .up_valid_i (vld[k]),
      .up_data_i  (dat[k]),
      .dn_ready_i (dn_rdy[k]),
      .ready_o    (st_rdy[k]),
      .valid_d_o  (vld_d[k]),
      .valid_o    (vld[k+1]),
      .data_o     (dat[k+1])
    );
  end

  assign in_ready  = st_rdy[0] & ~flush;
  assign out_valid = vld[DEPTH];
  assign out_data  = dat[DEPTH];

  // Next occupancy is the population count of the next-state valid bits.
  always_comb begin
    occ_d = '0;
    for (int k = 0; k < DEPTH; k++) occ_d = occ_d + OCC_W'(vld_d[k]);
  end

  // Registered occupancy so it lines up with the stage valid bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) occ_q <= '0;
    else      occ_q <= occ_d;
  end

  assign occupancy = occ_q;

endmodule : pipe_register

// File: tb/tb_pipe_register.sv
// Scoreboard bench for pipe_register (WIDTH=8, DEPTH=3).
module tb_pipe_register;

  localparam int         W  = 8;
  localparam int         D  = 3;
  localparam logic [7:0] RV = 8'hE7;

  logic         clk, rst;
  logic         in_valid, in_ready, out_valid, out_ready, flush;
  logic [W-1:0] in_data, out_data;
  logic [1:0]   occupancy;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] q[$];
  logic [D-1:0] mv;

  pipe_register #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .flush     (flush),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic setin(input logic v, input logic [7:0] d, input logic ordy, input logic fl);
    in_valid = v; in_data = d; out_ready = ordy; flush = fl;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic ordy, input logic fl);
    setin(v, d, ordy, fl);
    step();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  // Monitor: reference valid-bit model plus FIFO of expected data.
  always @(negedge clk) begin
    logic r0, r1, r2, er;
    logic [D-1:0] nv;
    if (!rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, RV);
      chk("rst_occupancy", occupancy, 0);
      mv = '0;
      q.delete();
    end else begin
      r2 = !mv[2] || out_ready;
      r1 = !mv[1] || r2;
      r0 = !mv[0] || r1;
      er = r0 && !flush;
      chk("in_ready", in_ready, er);
      chk("out_valid", out_valid, mv[2]);
      chk("occupancy", occupancy, $countones(mv));
      if (mv[2]) begin
        if (q.size() == 0) chk("sb_underflow", q.size(), 1);
        else               chk("out_data", out_data, q[0]);
        if (out_ready && q.size() != 0) void'(q.pop_front());
      end
      if (in_valid && er) q.push_back(in_data);
      if (flush) begin
        mv = '0;
        q.delete();
      end else begin
        nv = mv;
        if (r2) nv[2] = mv[1];
        if (r1) nv[1] = mv[0];
        if (r0) nv[0] = in_valid;
        mv = nv;
      end
    end
  end

  initial begin
    rst = 1'b0;
    setin(1'b0, 8'h00, 1'b0, 1'b0);
    #12;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, RV);
    chk("reset_occupancy", occupancy, 0);
    step();
    rst = 1'b1;

    // Latency and order with out_ready held high.
    drive(1'b1, 8'h11, 1'b1, 1'b0);
    chk("lat_c1_out_valid", out_valid, 0);
    drive(1'b1, 8'h22, 1'b1, 1'b0);
    chk("lat_c2_out_valid", out_valid, 0);
    drive(1'b1, 8'h33, 1'b1, 1'b0);
    chk("lat_c3_out_valid", out_valid, 1);
    chk("lat_c3_out_data", out_data, 8'h11);
    drain(4);

    // Backpressure: fourth word held off, head stays stable.
    drive(1'b1, 8'hA0, 1'b0, 1'b0);
    drive(1'b1, 8'hA1, 1'b0, 1'b0);
    drive(1'b1, 8'hA2, 1'b0, 1'b0);
    setin(1'b1, 8'hA3, 1'b0, 1'b0); #1;
    chk("full_in_ready", in_ready, 0);
    chk("full_occupancy", occupancy, 3);
    step();
    chk("stall_out_data", out_data, 8'hA0);
    chk("stall_in_ready", in_ready, 0);
    step();
    chk("stall2_out_data", out_data, 8'hA0);
    drain(4);

    // Flush with a concurrent output transfer and input offer.
    drive(1'b1, 8'hA0, 1'b0, 1'b0);
    drive(1'b1, 8'hB1, 1'b0, 1'b0);
    drive(1'b1, 8'hC2, 1'b0, 1'b0);
    setin(1'b1, 8'h55, 1'b1, 1'b1); #1;
    chk("flush_in_ready", in_ready, 0);
    chk("flush_out_valid", out_valid, 1);
    chk("flush_out_data", out_data, 8'hA0);
    step();
    chk("post_flush_occupancy", occupancy, 0);
    chk("post_flush_out_valid", out_valid, 0);
    drain(4);

    // Streaming with toggling out_ready.
    for (int i = 0; i < 12; i++) drive(1'b1, 8'h60 + 8'(i), (i % 2) == 0, 1'b0);
    drain(5);

    // Bubble collapse: stage 2 stalled, stage 1 empty, stage 0 valid.
    drive(1'b1, 8'hD0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'hD1, 1'b0, 1'b0);
    chk("bubble_occupancy", occupancy, 2);
    setin(1'b1, 8'hD2, 1'b0, 1'b0); #1;
    chk("bubble_in_ready", in_ready, 1);
    step();
    chk("bubble_after_occupancy", occupancy, 3);
    drain(4);

    // Asynchronous reset mid-stream, then accept on first edge.
    drive(1'b1, 8'h21, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("pre_rst_out_valid", out_valid, 1);
    chk("pre_rst_out_data", out_data, 8'h21);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_out_data", out_data, RV);
    chk("async_rst_occupancy", occupancy, 0);
    step();
    rst = 1'b1;
    setin(1'b1, 8'h77, 1'b1, 1'b0); #1;
    chk("rst_release_in_ready", in_ready, 1);
    step();
    chk("rst_release_occupancy", occupancy, 1);
    drain(4);

    chk("sb_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pipe_register

// File: doc/pipe_register.md
PIPE_REGISTER -- requirements
Module: pipe_register

Interface
REQ-001 Parameter WIDTH, default 32: data width in bits, legal range 1..256.
REQ-002 Parameter DEPTH, default 2: number of register stages, legal range 1..8.
REQ-003 Parameter RESET_VAL, default 0: WIDTH-bit value loaded into every stage's data on reset.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; asynchronous and active-low (asserted when 0).
REQ-006 in_valid  input  1  producer offers in_data this cycle.
REQ-007 in_data  input  WIDTH  producer data.
REQ-008 in_ready  output  1  pipeline accepts in_data this cycle.
REQ-009 out_valid  output  1  stage DEPTH-1 holds valid data.
REQ-010 out_data  output  WIDTH  data of stage DEPTH-1.
REQ-011 out_ready  input  1  consumer accepts out_data this cycle.
REQ-012 flush  input  1  synchronous discard of all in-flight entries.
REQ-013 occupancy  output  $clog2(DEPTH+1)  count of valid stages, registered.

Function
REQ-014 Stage k SHALL hold a data register (WIDTH) and a valid bit; stage 0 is the input end and stage DEPTH-1 drives the output.
REQ-015 Stage k SHALL be ready when it is empty or when stage k+1 is ready; the ready of stage DEPTH-1 is out_ready.
REQ-016 in_ready SHALL equal stage-0 ready AND NOT flush, combinationally.
REQ-017 An input transfer SHALL occur on a cycle when in_valid=1 and in_ready=1; an output transfer SHALL occur on a cycle when out_valid=1 and out_ready=1.
REQ-018 A ready stage SHALL load its data and valid from the previous stage (or from in_data/in_valid for stage 0) on the clock edge; a not-ready stage SHALL hold its data and valid.
REQ-019 Data in an empty stage SHALL NOT be updated unless the incoming valid is 1, so that the stage stays bubble-quiet for power.
REQ-020 Latency SHALL be exactly DEPTH cycles from input transfer to out_valid when out_ready is held at 1.
REQ-021 Sustained throughput SHALL be one transfer per cycle when in_valid and out_ready are both held at 1.
REQ-022 Bubbles SHALL collapse: a stall at the output SHALL fill empty upstream stages before in_ready falls.
REQ-023 in_ready SHALL fall only when all DEPTH stages are valid and out_ready=0.
REQ-024 flush=1 SHALL clear every valid bit at the next edge; data registers hold, and occupancy becomes 0.
REQ-025 flush and an output transfer in the same cycle: the output transfer completes; all other entries are discarded.
REQ-026 flush and in_valid in the same cycle: no input transfer occurs (in_ready=0), and the entry is not stored.
REQ-027 occupancy SHALL be computed from the valid bits, registered, and SHALL count +1 on input-only transfers, -1 on output-only transfers, and be unchanged when both or neither occur, never exceeding DEPTH.
REQ-028 out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-029 Data ordering SHALL be strict first-in, first-out; no entry is duplicated or dropped except by flush.

Reset
REQ-030 While rst=0, every valid bit SHALL be 0, every data register RESET_VAL, occupancy 0, out_valid 0, and out_data RESET_VAL, taking effect immediately without a clock.
REQ-031 Reset assertion mid-operation SHALL discard all entries; the first input transfer SHALL be possible on the first rising edge after rst returns to 1.

Structure
REQ-032 The valid/ready stage SHALL be a sub-module pipe_register_stage (WIDTH, RESET_VAL), instantiated DEPTH times via generate.
REQ-033 The limits PIPE_REG_MAX_DEPTH=8 and PIPE_REG_MAX_WIDTH=256 SHALL live in the shared global definitions package; no typedefs are needed.
REQ-034 Out-of-range parameters SHALL cause an elaboration-time error.

Verification (WIDTH=8, DEPTH=3)
REQ-035 Reset then send 0x11,0x22,0x33 on consecutive cycles with out_ready=1 -> out_valid first high 3 cycles after 0x11 is accepted, and outputs read 0x11,0x22,0x33 in order.
REQ-036 out_ready=0, send 0xA0..0xA3 -> in_ready falls after 3 accepts, 0xA3 is held off, occupancy=3, out_data stays 0xA0 until out_ready=1.
REQ-037 Fill 3 entries, then assert flush with in_valid=1 data 0x55 and out_ready=1 -> 0xA0 is delivered, next cycle occupancy=0, out_valid=0, 0x55 is never output.
REQ-038 Streaming with out_ready toggling 1,0,1,0 -> no loss or duplication, and occupancy tracks the scoreboard every cycle.
REQ-039 Assert rst mid-stream with 2 entries -> out_valid=0 and out_data=RESET_VAL immediately; after release, 0x77 is accepted on the first edge.
REQ-040 Bubble collapse: stage 2 valid and stalled, stage 1 empty, stage 0 valid -> stage 0's entry advances to stage 1 while in_ready stays 1.
